// File: rtl/relu_out_buffer_pkg.sv
// Shared widths and FSM encoding for the ReLU output buffer.
// Used by the interface, the FIFO wrapper logic and the top.
package relu_out_buffer_pkg;

    localparam int WORD_W          = 32;
    localparam int FLAG_W          = 7;
    localparam int GROUPS_PER_WORD = 4;
    localparam int FLAG_BITS       = FLAG_W * GROUPS_PER_WORD;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/relu_out_buffer_if.sv
// Write port towards the global output buffer (GB_OUT).
// The master drives the write strobe/data/select and the slave returns ready.
interface relu_out_buffer_if;
    import relu_out_buffer_pkg::*;

    logic              gb_wr_en;
    logic [WORD_W-1:0] gb_wr_data;
    logic              gb_wr_sel;
    logic              GB_OUT_ready;

    modport master (output gb_wr_en, output gb_wr_data, output gb_wr_sel, input GB_OUT_ready);
    modport slave  (input gb_wr_en, input gb_wr_data, input gb_wr_sel, output GB_OUT_ready);

endinterface

// File: rtl/relu_out_buffer_fifo.sv
// Synchronous show-ahead FIFO (module sync_fifo), power-of-two depth.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/relu_out_buffer.sv
// Buffers packed ReLU data words and packed nonzero-flag words, drains them to GB_OUT.
// Optional RELU_OUT_BUF_STAT_EN adds per-type written-word counters.
module relu_out_buffer
    import relu_out_buffer_pkg::*;
#(
    parameter int DATA_DEPTH = 8,
    parameter int FLAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic              flag_in_valid,
    input  logic              frame_end,
    relu_out_buffer_if.master gb,
    output logic              frame_done,
`ifdef RELU_OUT_BUF_STAT_EN
    output logic [15:0]       stat_data_cnt,
    output logic [15:0]       stat_flag_cnt,
`endif
    output logic              overflow
);

    buf_state_t           state;
    buf_state_t           state_next;
    logic [1:0]           grp_cnt;
    logic [1:0]           grp_next;
    logic [FLAG_BITS-1:0] flag_acc;
    logic [FLAG_BITS-1:0] acc_next;
    logic [FLAG_BITS-1:0] acc_merged;
    logic [FLAG_BITS-1:0] push_acc;
    logic                 flag_push;
    logic                 fe_live;
    logic [WORD_W-1:0]    data_rd;
    logic [WORD_W-1:0]    flag_rd;
    logic                 data_full;
    logic                 data_empty;
    logic                 flag_full;
    logic                 flag_empty;
    logic                 pop_data;
    logic                 pop_flag;

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(data_in_valid), .push_data(data_in),
        .pop(pop_data), .pop_data(data_rd),
        .full(data_full), .empty(data_empty)
    );

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(FLAG_DEPTH)) u_flag_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(flag_push), .push_data({{(WORD_W-FLAG_BITS){1'b0}}, push_acc}),
        .pop(pop_flag), .pop_data(flag_rd),
        .full(flag_full), .empty(flag_empty)
    );

    // A same-cycle group is merged before a frame_end closes a partial word.
    always_comb begin
        acc_merged = flag_acc | (FLAG_BITS'(flag_in) << (FLAG_W * int'(grp_cnt)));
        fe_live    = frame_end & (state == ST_RUN);
        acc_next   = flag_acc;
        grp_next   = grp_cnt;
        flag_push  = 1'b0;
        push_acc   = '0;
        if (flag_in_valid) begin
            acc_next = acc_merged;
            grp_next = grp_cnt + 2'd1;
            if (grp_cnt == 2'd3) begin
                flag_push = 1'b1;
                push_acc  = acc_merged;
                acc_next  = '0;
                grp_next  = 2'd0;
            end
        end
        if (fe_live) begin
            if (!flag_push && (flag_in_valid || grp_cnt != 2'd0)) begin
                flag_push = 1'b1;
                push_acc  = acc_next;
            end
            acc_next = '0;
            grp_next = 2'd0;
        end
    end

    assign pop_flag   = gb.GB_OUT_ready & ~flag_empty;
    assign pop_data   = gb.GB_OUT_ready & flag_empty & ~data_empty;
    assign frame_done = (state == ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (frame_end) state_next = ST_FLUSH;
            ST_FLUSH: if (flag_empty && data_empty) state_next = ST_DONE;
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            grp_cnt       <= 2'd0;
            flag_acc      <= '0;
            overflow      <= 1'b0;
            gb.gb_wr_en   <= 1'b0;
            gb.gb_wr_data <= '0;
            gb.gb_wr_sel  <= 1'b0;
        end else begin
            state    <= state_next;
            grp_cnt  <= grp_next;
            flag_acc <= acc_next;
            if ((data_in_valid && data_full && !pop_data) || (flag_push && flag_full && !pop_flag))
                overflow <= 1'b1;
            gb.gb_wr_en <= pop_flag | pop_data;
            if (pop_flag || pop_data) begin
                gb.gb_wr_data <= pop_flag ? flag_rd : data_rd;
                gb.gb_wr_sel  <= pop_flag;
            end
        end
    end

`ifdef RELU_OUT_BUF_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_data_cnt <= 16'd0;
            stat_flag_cnt <= 16'd0;
        end else if (frame_done) begin
            stat_data_cnt <= 16'd0;
            stat_flag_cnt <= 16'd0;
        end else if (gb.gb_wr_en) begin
            if (gb.gb_wr_sel && stat_flag_cnt != 16'hFFFF)
                stat_flag_cnt <= stat_flag_cnt + 16'd1;
            if (!gb.gb_wr_sel && stat_data_cnt != 16'hFFFF)
                stat_data_cnt <= stat_data_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_relu_out_buffer.sv
// Self-checking bench for relu_out_buffer: per-cycle vector table plus
// hand-written overflow and mid-flush reset sequences.
module tb_relu_out_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [6:0]  flag_in = '0;
    logic        flag_in_valid = 1'b0;
    logic        frame_end = 1'b0;
    logic        frame_done;
    logic        overflow;
`ifdef RELU_OUT_BUF_STAT_EN
    logic [15:0] stat_data_cnt;
    logic [15:0] stat_flag_cnt;
`endif

    int errors = 0;
    int checks = 0;

    relu_out_buffer_if gb();

    relu_out_buffer #(.DATA_DEPTH(8), .FLAG_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .flag_in(flag_in),
        .flag_in_valid(flag_in_valid),
        .frame_end(frame_end),
        .gb(gb),
        .frame_done(frame_done),
`ifdef RELU_OUT_BUF_STAT_EN
        .stat_data_cnt(stat_data_cnt),
        .stat_flag_cnt(stat_flag_cnt),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        dv;
        logic [31:0] d;
        logic        fv;
        logic [6:0]  f;
        logic        fe;
        logic        rdy;
        logic        e_en;
        logic [31:0] e_data;
        logic        e_sel;
        logic        e_done;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic dv, input logic [31:0] d,
                          input logic fv, input logic [6:0] f, input logic fe, input logic rdy,
                          input logic e_en, input logic [31:0] e_data, input logic e_sel,
                          input logic e_done, input logic e_ovf);
        vec_t v;
        v.name = name; v.dv = dv; v.d = d; v.fv = fv; v.f = f; v.fe = fe; v.rdy = rdy;
        v.e_en = e_en; v.e_data = e_data; v.e_sel = e_sel; v.e_done = e_done; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic dv, input logic [31:0] d, input logic fv,
                                 input logic [6:0] f, input logic fe, input logic rdy);
        data_in_valid   = dv;
        data_in         = d;
        flag_in_valid   = fv;
        flag_in         = f;
        frame_end       = fe;
        gb.GB_OUT_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic en, input logic [31:0] data,
                            input logic sel, input logic done, input logic ovf);
        checkOutput({tag, ".wr_en"}, {31'd0, gb.gb_wr_en}, {31'd0, en});
        checkOutput({tag, ".wr_data"}, gb.gb_wr_data, data);
        checkOutput({tag, ".wr_sel"}, {31'd0, gb.gb_wr_sel}, {31'd0, sel});
        checkOutput({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, done});
        checkOutput({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ovf});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        applyStimulus(0, 0, 0, 0, 0, 1);
        #12;
        checkAll("reset", 0, 32'h0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // three data words, first write two cycles after first strobe
        addVec("d0", 1, 32'h11223344, 0, 0, 0, 1, 0, 32'h00000000, 0, 0, 0);
        addVec("d1", 1, 32'h55667788, 0, 0, 0, 1, 1, 32'h11223344, 0, 0, 0);
        addVec("d2", 1, 32'h99AABBCC, 0, 0, 0, 1, 1, 32'h55667788, 0, 0, 0);
        addVec("d3", 0, 0,            0, 0, 0, 1, 1, 32'h99AABBCC, 0, 0, 0);
        addVec("d4", 0, 0,            0, 0, 0, 1, 0, 32'h99AABBCC, 0, 0, 0);
        // four groups pack into one word: bit 7*g+i
        addVec("f0", 0, 0, 1, 7'h01, 0, 1, 0, 32'h99AABBCC, 0, 0, 0);
        addVec("f1", 0, 0, 1, 7'h02, 0, 1, 0, 32'h99AABBCC, 0, 0, 0);
        addVec("f2", 0, 0, 1, 7'h04, 0, 1, 0, 32'h99AABBCC, 0, 0, 0);
        addVec("f3", 0, 0, 1, 7'h7F, 0, 1, 0, 32'h99AABBCC, 0, 0, 0);
        addVec("f4", 0, 0, 0, 0,     0, 1, 1, 32'h0FE10101, 1, 0, 0);
        addVec("f5", 0, 0, 0, 0,     0, 1, 0, 32'h0FE10101, 1, 0, 0);
        // partial word closed by frame_end, then frame_done
        addVec("p0", 0, 0, 1, 7'h7F, 0, 1, 0, 32'h0FE10101, 1, 0, 0);
        addVec("p1", 0, 0, 1, 7'h7F, 0, 1, 0, 32'h0FE10101, 1, 0, 0);
        addVec("p2", 0, 0, 0, 0,     1, 1, 0, 32'h0FE10101, 1, 0, 0);
        addVec("p3", 0, 0, 0, 0,     0, 1, 1, 32'h00003FFF, 1, 0, 0);
        addVec("p4", 0, 0, 0, 0,     0, 1, 0, 32'h00003FFF, 1, 1, 0);
        addVec("p5", 0, 0, 0, 0,     0, 1, 0, 32'h00003FFF, 1, 0, 0);
        // flag word has priority over a pending data word
        addVec("q0", 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 32'h00003FFF, 1, 0, 0);
        addVec("q1", 0, 0, 1, 7'h01, 0, 0, 0, 32'h00003FFF, 1, 0, 0);
        addVec("q2", 0, 0, 1, 7'h00, 0, 0, 0, 32'h00003FFF, 1, 0, 0);
        addVec("q3", 0, 0, 1, 7'h00, 0, 0, 0, 32'h00003FFF, 1, 0, 0);
        addVec("q4", 0, 0, 1, 7'h00, 0, 0, 0, 32'h00003FFF, 1, 0, 0);
        addVec("q5", 0, 0, 0, 0,     0, 1, 1, 32'h00000001, 1, 0, 0);
        addVec("q6", 0, 0, 0, 0,     0, 1, 1, 32'hA5A5A5A5, 0, 0, 0);
        addVec("q7", 0, 0, 0, 0,     0, 1, 0, 32'hA5A5A5A5, 0, 0, 0);
        // frame_end with a same-cycle group: 0x03 | 0x05<<7
        addVec("s0", 0, 0, 1, 7'h03, 0, 1, 0, 32'hA5A5A5A5, 0, 0, 0);
        addVec("s1", 0, 0, 1, 7'h05, 1, 1, 0, 32'hA5A5A5A5, 0, 0, 0);
        addVec("s2", 0, 0, 0, 0,     0, 1, 1, 32'h00000283, 1, 0, 0);
        addVec("s3", 0, 0, 0, 0,     0, 1, 0, 32'h00000283, 1, 1, 0);
        addVec("s4", 0, 0, 0, 0,     0, 1, 0, 32'h00000283, 1, 0, 0);
        // frame_end with empty accumulator: no push, straight to done
        addVec("e0", 0, 0, 0, 0,     1, 1, 0, 32'h00000283, 1, 0, 0);
        addVec("e1", 0, 0, 0, 0,     0, 1, 0, 32'h00000283, 1, 1, 0);
        addVec("e2", 0, 0, 0, 0,     0, 1, 0, 32'h00000283, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].dv, vecs[i].d, vecs[i].fv, vecs[i].f, vecs[i].fe, vecs[i].rdy);
            tick();
            checkAll(vecs[i].name, vecs[i].e_en, vecs[i].e_data, vecs[i].e_sel,
                     vecs[i].e_done, vecs[i].e_ovf);
        end

        // overflow: nine strobes into an eight-deep FIFO with ready low
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 32'h100 + i, 0, 0, 0, 0);
            tick();
            if (i == 7) checkOutput("ovf.after8", {31'd0, overflow}, 32'd0);
            if (i == 8) checkOutput("ovf.after9", {31'd0, overflow}, 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gb.gb_wr_en) begin
                checkOutput("ovf.word", gb.gb_wr_data, 32'h100 + n);
                checkOutput("ovf.sel", {31'd0, gb.gb_wr_sel}, 32'd0);
                n++;
            end
        end
        checkOutput("ovf.count", n, 32'd8);
        checkOutput("ovf.sticky", {31'd0, overflow}, 32'd1);

        // reset asserted while flushing with a write in flight
        applyStimulus(1, 32'hDEAD0001, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'hDEAD0002, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("rst.pre_en", {31'd0, gb.gb_wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1 checkAll("rst.async", 0, 32'h0, 0, 0, 0);
        repeat (2) begin
            tick();
            checkOutput("rst.hold_done", {31'd0, frame_done}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        checkAll("rst.empty", 0, 32'h0, 0, 0, 0);
        applyStimulus(1, 32'hCAFEF00D, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();
        checkAll("rst.next_word", 1, 32'hCAFEF00D, 0, 0, 0);
        tick();
        checkAll("rst.idle", 0, 32'hCAFEF00D, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();
        checkAll("rst.frame_done", 0, 32'hCAFEF00D, 0, 1, 0);
        tick();
        checkAll("rst.back_run", 0, 32'hCAFEF00D, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
